uart_cmd_slave: RTL and testbench
=================================

# uart_cmd_slave

Responder end of the team's 2-frame UART command link. It receives a 16-bit command as two UART frames, low byte first, and decodes a write/read flag, a 7-bit address and an 8-bit write data field. Writes drive a single-cycle register write strobe. Reads fetch one byte from the register bus and return it to the command master as one UART frame after a fixed turnaround. It sits between the board-level rx/tx pins and the local register bank.

## Interface
Parameters:
- BR, 434: clocks per UART bit (50 MHz / 115200); legal 16..511
- TURN_CYC, 400: clocks from byte-1 stop-bit mid-sample to response start-bit begin; must be > BR/2+101
- BYTE_TO, 20000: clocks allowed from byte-0 completion to byte-1 start-bit edge

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- rx  in  1  serial input, asynchronous to clk
- tx  out  1  serial output, idle high
- reg_wr  out  1  one-cycle write strobe
- reg_rd  out  1  one-cycle read strobe
- reg_addr  out  7  register address, held until next command
- reg_wdata  out  8  write data, held until next command
- reg_rdata  in  8  read data, valid the cycle after reg_rd
- busy  out  1  high from byte-0 start detect until command fully handled
- err  out  1  one-cycle pulse on parity, framing or timeout error

## Operation
- Reset values: tx=1; reg_wr=0, reg_rd=0, reg_addr=0, reg_wdata=0, busy=0, err=0. Reset takes effect asynchronously at any point, including mid-frame or mid-response.
- rx passes through a 2-flop synchroniser. A start is a 1→0 edge on the synchronised rx.
- Frame format: start(0), 8 data bits LSB first, odd parity (XNOR-reduce of the data bits, so the total count of ones is odd), stop(1).
- Command fields: byte0 = cmd[7:0] = data. byte1 = cmd[15:8] = {rw, addr[6:0]}. rw=1 means write, rw=0 means read.
- State machine:
  - IDLE: on start edge → START_CHK.
  - START_CHK: at count BR/2, rx=0 → DATA; rx=1 → false start, return to previous wait state, no err.
  - DATA: one sample every BR clocks at bit centre, 8 bits.
  - PARITY: sample at bit centre.
  - STOP: sample at bit centre. Stop=0 or parity mismatch → err pulse, command dropped, → IDLE. Otherwise byte done.
  - After byte0 → WAIT_B1, which counts BYTE_TO. Start edge → START_CHK for byte1. Timeout → err pulse, → IDLE.
  - After byte1:
    - Write: reg_wr=1 for exactly one cycle with reg_addr/reg_wdata updated in that same cycle → IDLE.
    - Read: reg_rd=1 for one cycle. Capture reg_rdata on the next cycle. → TURN.
  - TURN: count TURN_CYC (counted from the stop mid-sample) → TX_START → TX_DATA (8) → TX_PAR → TX_STOP, each exactly BR clocks → IDLE.
- rx is ignored in TURN and TX_* states (half-duplex). A start edge there is not detected.

## Timing
- Bit counter runs 0..BR-1, so each bit is exactly BR clocks. Sample point is count BR/2 (integer division).
- Byte done is flagged at the stop-bit mid-sample; the rest of the stop bit is not waited for.
- Write latency: reg_wr asserts on the cycle after the byte-1 stop mid-sample.
- Read latency: reg_rd on the cycle after the stop mid-sample. tx falls TURN_CYC clocks after the stop mid-sample.
- Response frame: 10·BR clocks, or 11·BR with parity. busy falls the cycle the stop bit completes.
- err and a strobe never assert in the same cycle.

## Configuration
- UART_SLV_PARITY_EN defined: parity bit checked on receive and generated on transmit (11-bit frame).
- UART_SLV_PARITY_EN undefined: 8N1 frames. The PARITY and TX_PAR states are removed, and parity errors cannot occur.

## Structure
- Package uart_cmd_pkg holds:
  - the state enum
  - the default BR
  - the field positions RW_BIT=7 and ADDR_MSB=6
  - an odd-parity function
- One sub-module, uart_slv_rx, is natural. It contains the synchroniser, start check, bit sampling, and byte/parity/framing status, plus an enable input tied low in TURN and TX_*.
- The top level holds the command FSM, the timers and the transmitter.

## Test plan
- Write frames byte0=0xA5, byte1=0x93 → one reg_wr pulse with addr=0x13, wdata=0xA5; tx stays 1; err=0.
- Read frames byte0=0x00, byte1=0x2A, reg_rdata=0x3C → reg_rd pulse with addr=0x2A. tx start edge exactly 400 clocks after the stop mid-sample. Decoded frame is 0x3C with parity 1.
- Write with a corrupted parity bit → err pulse after byte1, no reg_wr. A following valid command executes normally.
- 100-clock low glitch on rx in IDLE → no err, no byte. A subsequent valid frame is received correctly.
- Byte0 sent, then no byte1 for 20000 clocks → err pulse on the timeout cycle, busy=0. A later complete command works.
- Assert rst_n low during response TX_DATA → tx=1 immediately and all outputs at reset values. With UART_SLV_PARITY_EN undefined, repeat the write and read tests with 10-bit frames.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared types and constants for the UART command responder.
// Optional parity support is selected with UART_SLV_PARITY_EN.
package uart_cmd_pkg;

    localparam int BR_DEF   = 434;
    localparam int RW_BIT   = 7;
    localparam int ADDR_MSB = 6;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RX_B0,
        S_WAIT_B1,
        S_RX_B1,
        S_TURN,
        S_TX_START,
        S_TX_DATA,
`ifdef UART_SLV_PARITY_EN
        S_TX_PAR,
`endif
        S_TX_STOP
    } state_t;

    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
`ifdef UART_SLV_PARITY_EN
        R_PAR,
`endif
        R_STOP
    } rx_state_t;

    function automatic logic odd_par(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/uart_slv_rx.sv
// uart_slv_rx: synchroniser, start check and byte sampler.
// Parity bit is present only when UART_SLV_PARITY_EN is defined.
module uart_slv_rx
    import uart_cmd_pkg::*;
#(
    parameter int BR = BR_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       en,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] data
);

    localparam int CW = 9;
    localparam logic [CW-1:0] HALF = CW'(BR / 2);
    localparam logic [CW-1:0] LAST = CW'(BR - 1);

    logic          s1, s2, sp;
    rx_state_t     st, st_n;
    logic [CW-1:0] cnt;
    logic [2:0]    bi;
    logic          mid, start, ok;
`ifdef UART_SLV_PARITY_EN
    logic          par;
`endif

    assign mid   = (cnt == HALF);
    assign start = en && (st == R_IDLE) && sp && !s2;
    assign busy  = (st != R_IDLE);
`ifdef UART_SLV_PARITY_EN
    assign ok    = s2 && (par == odd_par(data));
`else
    assign ok    = s2;
`endif
    assign done  = (st == R_STOP) && mid && ok;
    assign err   = (st == R_STOP) && mid && !ok;

    // two-flop synchroniser plus edge history, idle level high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            sp <= 1'b1;
        end else begin
            s1 <= rx;
            s2 <= s1;
            sp <= s2;
        end
    end

    // receive state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= R_IDLE;
        else        st <= st_n;
    end

    // receive next-state: every sample lands at the bit centre
    always_comb begin
        st_n = st;
        unique case (st)
            R_IDLE:  if (start) st_n = R_START;
            R_START: if (mid) st_n = s2 ? R_IDLE : R_DATA;
`ifdef UART_SLV_PARITY_EN
            R_DATA:  if (mid && bi == 3'd7) st_n = R_PAR;
            R_PAR:   if (mid) st_n = R_STOP;
`else
            R_DATA:  if (mid && bi == 3'd7) st_n = R_STOP;
`endif
            R_STOP:  if (mid) st_n = R_IDLE;
            default: st_n = R_IDLE;
        endcase
    end

    // bit timer restarts on the start edge, shift in LSB first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            bi   <= '0;
            data <= '0;
`ifdef UART_SLV_PARITY_EN
            par  <= 1'b0;
`endif
        end else begin
            cnt <= (start || cnt == LAST) ? '0 : cnt + 1'b1;
            if (st == R_START && mid) bi <= '0;
            if (st == R_DATA && mid) begin
                data <= {s2, data[7:1]};
                bi   <= bi + 3'd1;
            end
`ifdef UART_SLV_PARITY_EN
            if (st == R_PAR && mid) par <= s2;
`endif
        end
    end

endmodule

// File: rtl/uart_cmd_slave.sv
// uart_cmd_slave: 2-frame command decoder, register strobes, reply TX.
// Define UART_SLV_PARITY_EN for 8O1 frames; 8N1 otherwise.
module uart_cmd_slave
    import uart_cmd_pkg::*;
#(
    parameter int BR       = BR_DEF,
    parameter int TURN_CYC = 400,
    parameter int BYTE_TO  = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       tx,
    output logic       reg_wr,
    output logic       reg_rd,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       err
);

    localparam int T1   = (BYTE_TO > TURN_CYC) ? BYTE_TO : TURN_CYC;
    localparam int TMAX = (T1 > BR) ? T1 : BR;
    localparam int TW   = $clog2(TMAX + 1);

    state_t        state, state_n;
    logic [TW-1:0] tmr;
    logic          tmr_clr, bit_end;
    logic [2:0]    bidx, bidx_n;
    logic [7:0]    b0, txd;
    logic          cap_pend;
    logic          wr_n, rd_n, err_n, tx_n;
    logic          rx_en, rx_busy, rx_done, rx_err;
    logic [7:0]    rx_data;

    assign bit_end = (tmr == TW'(BR - 1));
    assign busy    = (state != S_IDLE);
    assign rx_en   = (state == S_IDLE) || (state == S_RX_B0) ||
                     (state == S_WAIT_B1) || (state == S_RX_B1);

    uart_slv_rx #(.BR(BR)) u_rx (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .en    (rx_en),
        .busy  (rx_busy),
        .done  (rx_done),
        .err   (rx_err),
        .data  (rx_data)
    );

    // command state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // command next-state, strobes and next tx level
    always_comb begin
        state_n = state;
        tmr_clr = 1'b0;
        bidx_n  = bidx;
        wr_n    = 1'b0;
        rd_n    = 1'b0;
        err_n   = 1'b0;
        unique case (state)
            S_IDLE: if (rx_busy) state_n = S_RX_B0;
            S_RX_B0: begin
                if (rx_done) begin
                    state_n = S_WAIT_B1;
                    tmr_clr = 1'b1;
                end else if (rx_err) begin
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                end else if (!rx_busy) begin
                    state_n = S_IDLE;
                end
            end
            S_WAIT_B1: begin
                if (rx_busy) begin
                    state_n = S_RX_B1;
                end else if (tmr == TW'(BYTE_TO - 1)) begin
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                end
            end
            S_RX_B1: begin
                if (rx_done) begin
                    if (rx_data[RW_BIT]) begin
                        wr_n    = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        rd_n    = 1'b1;
                        state_n = S_TURN;
                        tmr_clr = 1'b1;
                    end
                end else if (rx_err) begin
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                end else if (!rx_busy) begin
                    state_n = S_WAIT_B1;
                end
            end
            S_TURN: begin
                if (tmr == TW'(TURN_CYC - 2)) begin
                    state_n = S_TX_START;
                    tmr_clr = 1'b1;
                end
            end
            S_TX_START: begin
                if (bit_end) begin
                    state_n = S_TX_DATA;
                    tmr_clr = 1'b1;
                    bidx_n  = 3'd0;
                end
            end
            S_TX_DATA: begin
                if (bit_end) begin
                    tmr_clr = 1'b1;
                    if (bidx == 3'd7) begin
`ifdef UART_SLV_PARITY_EN
                        state_n = S_TX_PAR;
`else
                        state_n = S_TX_STOP;
`endif
                    end else begin
                        bidx_n = bidx + 3'd1;
                    end
                end
            end
`ifdef UART_SLV_PARITY_EN
            S_TX_PAR: begin
                if (bit_end) begin
                    state_n = S_TX_STOP;
                    tmr_clr = 1'b1;
                end
            end
`endif
            S_TX_STOP: if (bit_end) state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
        case (state_n)
            S_TX_START: tx_n = 1'b0;
            S_TX_DATA:  tx_n = txd[bidx_n];
`ifdef UART_SLV_PARITY_EN
            S_TX_PAR:   tx_n = odd_par(txd);
`endif
            default:    tx_n = 1'b1;
        endcase
    end

    // timers, registered outputs and the read-data capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr       <= '0;
            bidx      <= '0;
            tx        <= 1'b1;
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
            err       <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            b0        <= '0;
            txd       <= '0;
            cap_pend  <= 1'b0;
        end else begin
            tmr      <= tmr_clr ? '0 : tmr + 1'b1;
            bidx     <= bidx_n;
            tx       <= tx_n;
            reg_wr   <= wr_n;
            reg_rd   <= rd_n;
            err      <= err_n;
            cap_pend <= reg_rd;
            if (cap_pend) txd <= reg_rdata;
            if (state == S_RX_B0 && rx_done) b0 <= rx_data;
            if (wr_n || rd_n) begin
                reg_addr  <= rx_data[ADDR_MSB:0];
                reg_wdata <= b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_slave.sv
// tb_uart_cmd_slave: table of commands plus timeout, glitch, reset cases.
// Frame length follows UART_SLV_PARITY_EN.
module tb_uart_cmd_slave;

    localparam int BR   = 210;
    localparam int TURN = 400;
    localparam int BTO  = 20000;
    localparam int HALF = BR / 2;
`ifdef UART_SLV_PARITY_EN
    localparam int NBIT = 11;
`else
    localparam int NBIT = 10;
`endif
    localparam int NB = NBIT - 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       tx, reg_wr, reg_rd, busy, err;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata = 8'h00;
    logic [7:0] rd_val = 8'h00;
    longint     cyc = 0;

    uart_cmd_slave #(.BR(BR), .TURN_CYC(TURN), .BYTE_TO(BTO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .tx        (tx),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // register bank: data valid only the cycle after reg_rd
    always @(posedge clk) reg_rdata <= reg_rd ? rd_val : 8'hEE;

    typedef struct {
        logic [2:0] kind;
        logic [6:0] addr;
        logic [7:0] wdata;
        longint     at;
    } ev_t;

    typedef struct {
        logic [7:0] d;
        longint     at;
    } txe_t;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] rdata;
        bit         bad;
        logic [2:0] kind;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [7:0] txb;
    } vec_t;

    ev_t  evq[$];
    txe_t txq[$];
    ev_t  em;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // strobe/err monitor against the event scoreboard
    always @(negedge clk) begin
        if (rst_n && (reg_wr || reg_rd || err)) begin
            if (evq.size() == 0) begin
                chk("ev_unexpected", {reg_wr, reg_rd, err}, 3'b000);
            end else begin
                em = evq.pop_front();
                chk("ev_kind", {reg_wr, reg_rd, err}, em.kind);
                chk("ev_time", cyc, em.at);
                if (em.kind != 3'b001) chk("ev_addr", reg_addr, em.addr);
                if (em.kind == 3'b100) chk("ev_wdata", reg_wdata, em.wdata);
                if (em.kind == 3'b001) chk("err_busy", busy, 1'b0);
            end
        end
    end

    // reply frame decoder
    initial begin : txmon
        txe_t        t;
        logic [10:0] fr;
        longint      f;
        bit          ab;
        fr = '0;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                f  = cyc;
                ab = 1'b0;
                if (txq.size() == 0) begin
                    chk("tx_unexpected", 1, 0);
                    repeat (NBIT * BR) @(negedge clk);
                end else begin
                    t = txq.pop_front();
                    chk("tx_start_time", f, t.at);
                    repeat (HALF) @(negedge clk);
                    fr[0] = tx;
                    for (int i = 1; i < NBIT; i++) begin
                        repeat (BR) @(negedge clk);
                        if (!rst_n) ab = 1'b1;
                        fr[i] = tx;
                    end
                    if (!ab) begin
                        chk("tx_start_bit", fr[0], 1'b0);
                        chk("tx_data", fr[8:1], t.d);
`ifdef UART_SLV_PARITY_EN
                        chk("tx_parity", fr[9], ~^t.d);
`endif
                        chk("tx_stop", fr[NB], 1'b1);
                        repeat (BR - HALF - 1) @(negedge clk);
                        chk("busy_before_end", busy, 1'b1);
                        @(negedge clk);
                        chk("busy_fall", busy, 1'b0);
                    end
                end
            end
        end
    end

    task automatic start_bit(output longint c);
        @(negedge clk);
        rx = 1'b0;
        c  = cyc;
        repeat (BR) @(negedge clk);
    endtask

    task automatic rest_bits(input logic [7:0] d, input bit bad);
        logic [10:0] fr;
`ifdef UART_SLV_PARITY_EN
        fr = {1'b1, (~^d) ^ bad, d, 1'b0};
`else
        fr = {1'b1, ~bad, d, 1'b0};
`endif
        for (int i = 1; i < NBIT; i++) begin
            rx = fr[i];
            repeat (BR) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 30000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30000) chk("busy_stuck", 1, 0);
        repeat (20) @(negedge clk);
    endtask

    task automatic run_cmd(input vec_t v);
        longint c0, c1;
        rd_val = v.rdata;
        start_bit(c0);
        rest_bits(v.b0, 1'b0);
        start_bit(c1);
        evq.push_back('{v.kind, v.addr, v.wdata, c1 + 4 + NB * BR + HALF});
        if (v.kind == 3'b010)
            txq.push_back('{v.txb, c1 + 3 + NB * BR + HALF + TURN});
        rest_bits(v.b1, v.bad);
        wait_idle();
    endtask

    vec_t   vt[5];
    vec_t   vx;
    longint c0;
    int     n;

    initial begin
        vt[0] = '{8'hA5, 8'h93, 8'h00, 1'b0, 3'b100, 7'h13, 8'hA5, 8'h00};
        vt[1] = '{8'h00, 8'h2A, 8'h3C, 1'b0, 3'b010, 7'h2A, 8'h00, 8'h3C};
        vt[2] = '{8'h5A, 8'h81, 8'h00, 1'b1, 3'b001, 7'h00, 8'h00, 8'h00};
        vt[3] = '{8'h11, 8'hFF, 8'h00, 1'b0, 3'b100, 7'h7F, 8'h11, 8'h00};
        vt[4] = '{8'hC3, 8'h05, 8'h81, 1'b0, 3'b010, 7'h05, 8'h00, 8'h81};

        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_wr", reg_wr, 1'b0);
        chk("rst_rd", reg_rd, 1'b0);
        chk("rst_addr", reg_addr, 7'h00);
        chk("rst_wdata", reg_wdata, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_cmd(vt[i]);
            if (vt[i].kind != 3'b001)
                chk("hold_addr", reg_addr, vt[i].addr);
            if (vt[i].kind == 3'b100)
                chk("hold_wdata", reg_wdata, vt[i].wdata);
            chk("tx_idle", tx, 1'b1);
        end

        @(negedge clk);
        rx = 1'b0;
        repeat (100) @(negedge clk);
        rx = 1'b1;
        repeat (300) @(negedge clk);
        chk("glitch_busy", busy, 1'b0);
        vx = '{8'h3C, 8'hC4, 8'h00, 1'b0, 3'b100, 7'h44, 8'h3C, 8'h00};
        run_cmd(vx);
        chk("glitch_next_addr", reg_addr, 7'h44);

        start_bit(c0);
        evq.push_back('{3'b001, 7'h00, 8'h00,
                        c0 + 3 + NB * BR + HALF + BTO + 1});
        rest_bits(8'h77, 1'b0);
        repeat (BTO + 100) @(negedge clk);
        chk("timeout_busy", busy, 1'b0);
        chk("timeout_seen", evq.size(), 0);
        vx = '{8'h12, 8'hA1, 8'h00, 1'b0, 3'b100, 7'h21, 8'h12, 8'h00};
        run_cmd(vx);

        vx = '{8'h00, 8'h33, 8'h96, 1'b0, 3'b010, 7'h33, 8'h00, 8'h96};
        rd_val = vx.rdata;
        start_bit(c0);
        rest_bits(vx.b0, 1'b0);
        start_bit(c0);
        evq.push_back('{vx.kind, vx.addr, vx.wdata,
                        c0 + 4 + NB * BR + HALF});
        txq.push_back('{vx.txb, c0 + 3 + NB * BR + HALF + TURN});
        rest_bits(vx.b1, 1'b0);
        n = 0;
        while (tx !== 1'b0 && n < TURN + 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst_test_tx_fell", tx, 1'b0);
        repeat (3 * BR) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tx", tx, 1'b1);
        chk("arst_wr", reg_wr, 1'b0);
        chk("arst_rd", reg_rd, 1'b0);
        chk("arst_addr", reg_addr, 7'h00);
        chk("arst_wdata", reg_wdata, 8'h00);
        chk("arst_busy", busy, 1'b0);
        chk("arst_err", err, 1'b0);
        repeat (2 * BR) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        vx = '{8'h6B, 8'hA2, 8'h00, 1'b0, 3'b100, 7'h22, 8'h6B, 8'h00};
        run_cmd(vx);
        chk("post_rst_addr", reg_addr, 7'h22);

        repeat (50) @(negedge clk);
        chk("evq_empty", evq.size(), 0);
        chk("txq_empty", txq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
